// File: rtl/field_access_arb_pkg.sv
// Shared types and helpers for the field access arbiter.
package field_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned alias_num);
    return sel < alias_num;
  endfunction

endpackage

// File: rtl/field_access_arb_if.sv
// Requester and field-side signals of the field access arbiter.
interface field_access_arb_if #(
  parameter int unsigned REQ_NUM   = 4,
  parameter int unsigned ALIAS_NUM = 2,
  parameter int unsigned F_WIDTH   = 4,
  parameter int unsigned SEL_WIDTH = (ALIAS_NUM > 1) ? $clog2(ALIAS_NUM) : 1
);
  logic [REQ_NUM-1:0]           req;
  logic [REQ_NUM-1:0]           req_wr;
  logic [REQ_NUM*SEL_WIDTH-1:0] req_sel;
  logic [REQ_NUM*F_WIDTH-1:0]   req_wdata;
  logic [REQ_NUM-1:0]           ack;
  logic [F_WIDTH-1:0]           rdata;
  logic                         err;
  logic                         busy;
  logic [ALIAS_NUM-1:0]         sw_wr;
  logic [ALIAS_NUM-1:0]         sw_rd;
  logic [ALIAS_NUM*F_WIDTH-1:0] sw_wr_data;
  logic [F_WIDTH-1:0]           field_value;

  // Requesters and the field instance, as seen from outside the arbiter.
  modport master (
    output req, req_wr, req_sel, req_wdata, field_value,
    input  ack, rdata, err, busy, sw_wr, sw_rd, sw_wr_data
  );

  modport slave (
    input  req, req_wr, req_sel, req_wdata, field_value,
    output ack, rdata, err, busy, sw_wr, sw_rd, sw_wr_data
  );
endinterface

// File: rtl/field_access_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    gnt
);
  localparam int unsigned W2 = 2 * N;

  logic [N-1:0]  mask;
  logic [W2-1:0] dreq;
  logic [W2-1:0] dgnt;

  // Low half holds requests at or above ptr, high half all requests for the wrap case;
  // isolating the lowest set bit then yields the round-robin winner.
  always_comb begin
    mask = ~((N'(1) << ptr) - N'(1));
    dreq = {req, req & mask};
    dgnt = dreq & (~dreq + W2'(1));
    gnt  = dgnt[N-1:0] | dgnt[W2-1:N];
  end

endmodule

// File: rtl/field_access_arb.sv
// Round-robin access sequencer sharing one multi-alias register field between requesters.
module field_access_arb
  import field_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM   = 4,
  parameter int unsigned ALIAS_NUM = 2,
  parameter int unsigned F_WIDTH   = 4,
  parameter int unsigned SEL_WIDTH = (ALIAS_NUM > 1) ? $clog2(ALIAS_NUM) : 1
) (
  input logic clk,
  input logic rst,
  field_access_arb_if.slave bus
);
  localparam int unsigned IdxW = $clog2(REQ_NUM);

  state_e                       state_q, state_d;
  logic [IdxW-1:0]              ptr_q, ptr_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic                         wr_q, wr_d;
  logic [SEL_WIDTH-1:0]         sel_q, sel_d;
  logic [REQ_NUM-1:0]           ack_q, ack_d;
  logic [ALIAS_NUM-1:0]         sw_wr_q, sw_wr_d;
  logic [ALIAS_NUM-1:0]         sw_rd_q, sw_rd_d;
  logic [ALIAS_NUM*F_WIDTH-1:0] sw_wr_data_q, sw_wr_data_d;
  logic [F_WIDTH-1:0]           rdata_q, rdata_d;
  logic                         err_q, err_d;

  logic [REQ_NUM-1:0]   gnt;
  logic [IdxW-1:0]      win_idx;
  logic                 win_wr;
  logic [SEL_WIDTH-1:0] win_sel;
  logic [F_WIDTH-1:0]   win_wdata;
  logic                 in_range;

  rr_arbiter #(
    .N(REQ_NUM)
  ) u_rr_arbiter (
    .req(bus.req),
    .ptr(ptr_q),
    .gnt(gnt)
  );

  always_comb begin
    win_idx   = '0;
    win_wr    = 1'b0;
    win_sel   = '0;
    win_wdata = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (gnt[i]) begin
        win_idx   = IdxW'(i);
        win_wr    = bus.req_wr[i];
        win_sel   = bus.req_sel[i*SEL_WIDTH +: SEL_WIDTH];
        win_wdata = bus.req_wdata[i*F_WIDTH +: F_WIDTH];
      end
    end
  end

  assign in_range = sel_in_range(32'(sel_q), ALIAS_NUM);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    wr_d         = wr_q;
    sel_d        = sel_q;
    ack_d        = '0;
    sw_wr_d      = '0;
    sw_rd_d      = '0;
    sw_wr_data_d = '0;
    rdata_d      = rdata_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d = StAccess;
          idx_d   = win_idx;
          wr_d    = win_wr;
          sel_d   = win_sel;
          ptr_d   = (win_idx == IdxW'(REQ_NUM - 1)) ? '0 : win_idx + 1'b1;
          // Strobes are registered here so they are high for exactly the ACCESS cycle;
          // an out-of-range select matches no alias and leaves everything at zero.
          for (int unsigned a = 0; a < ALIAS_NUM; a++) begin
            if (32'(win_sel) == a) begin
              sw_wr_d[a]                       = win_wr;
              sw_rd_d[a]                       = ~win_wr;
              sw_wr_data_d[a*F_WIDTH +: F_WIDTH] = win_wdata;
            end
          end
        end
      end
      StAccess: begin
        state_d      = StResp;
        err_d        = ~in_range;
        rdata_d      = (!wr_q && in_range) ? bus.field_value : '0;
        ack_d[idx_q] = 1'b1;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      idx_q        <= '0;
      wr_q         <= 1'b0;
      sel_q        <= '0;
      ack_q        <= '0;
      sw_wr_q      <= '0;
      sw_rd_q      <= '0;
      sw_wr_data_q <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      wr_q         <= wr_d;
      sel_q        <= sel_d;
      ack_q        <= ack_d;
      sw_wr_q      <= sw_wr_d;
      sw_rd_q      <= sw_rd_d;
      sw_wr_data_q <= sw_wr_data_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.sw_wr      = sw_wr_q;
  assign bus.sw_rd      = sw_rd_q;
  assign bus.sw_wr_data = sw_wr_data_q;

endmodule

// File: tb/tb_field_access_arb.sv
// Bench for field_access_arb: transaction-level model checked every cycle plus directed cases.
module tb_field_access_arb;
  localparam int unsigned R = 4;
  localparam int unsigned A = 2;
  localparam int unsigned F = 4;
  localparam int unsigned S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  field_access_arb_if #(.REQ_NUM(R), .ALIAS_NUM(A), .F_WIDTH(F), .SEL_WIDTH(S)) bus ();

  field_access_arb #(
    .REQ_NUM(R),
    .ALIAS_NUM(A),
    .F_WIDTH(F),
    .SEL_WIDTH(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Field: alias 0 read clears the value, alias 1 read has no side effect.
  logic [F-1:0] fld;
  always @(posedge clk or posedge rst) begin
    if (rst) fld <= '0;
    else if (bus.sw_wr[0]) fld <= bus.sw_wr_data[F-1:0];
    else if (bus.sw_wr[1]) fld <= bus.sw_wr_data[2*F-1:F];
    else if (bus.sw_rd[0]) fld <= '0;
  end
  assign bus.field_value = fld;

  // Transaction model: phase 0 waiting, 1 access cycle, 2 response cycle.
  int           m_phase = 0;
  int           m_ptr = 0;
  int           m_win = 0;
  int           m_sel = 0;
  logic         m_wr = 1'b0;
  logic [F-1:0] m_wdata = '0;
  logic [F-1:0] m_rdata = '0;
  logic         m_err = 1'b0;
  int           pick;
  int           grant_log[$];

  function automatic int rr_pick(input logic [R-1:0] r, input int p);
    for (int k = 0; k < R; k++) if (r[(p + k) % R]) return (p + k) % R;
    return 0;
  endfunction

  always_comb pick = rr_pick(bus.req, m_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_ptr   <= 0;
    end else if (m_phase == 0) begin
      if (bus.req != '0) begin
        m_win   <= pick;
        m_ptr   <= (pick + 1) % R;
        m_wr    <= bus.req_wr[pick];
        m_sel   <= int'(bus.req_sel[pick*S +: S]);
        m_wdata <= bus.req_wdata[pick*F +: F];
        grant_log.push_back(pick);
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_err   <= (m_sel >= A);
      m_rdata <= (!m_wr && m_sel < A) ? fld : '0;
      m_phase <= 2;
    end else begin
      m_phase <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic [A-1:0]   e_wr = '0;
    logic [A-1:0]   e_rd = '0;
    logic [A*F-1:0] e_data = '0;
    logic [R-1:0]   e_ack = '0;
    if (m_phase == 1 && m_sel < A) begin
      if (m_wr) e_wr[m_sel] = 1'b1;
      else e_rd[m_sel] = 1'b1;
      e_data[m_sel*F +: F] = m_wdata;
    end
    if (m_phase == 2) e_ack[m_win] = 1'b1;
    chk("m_ack", 32'(bus.ack), 32'(e_ack));
    chk("m_sw_wr", 32'(bus.sw_wr), 32'(e_wr));
    chk("m_sw_rd", 32'(bus.sw_rd), 32'(e_rd));
    chk("m_sw_wr_data", 32'(bus.sw_wr_data), 32'(e_data));
    chk("m_busy", 32'(bus.busy), 32'(m_phase != 0));
    if (m_phase == 2) begin
      chk("m_rdata", 32'(bus.rdata), 32'(m_rdata));
      chk("m_err", 32'(bus.err), 32'(m_err));
    end
  endtask

  initial forever begin
    @(negedge clk);
    check_cycle();
  end

  task automatic drive(input int i, input logic wr, input int sel, input logic [F-1:0] wd);
    bus.req[i]            = 1'b1;
    bus.req_wr[i]         = wr;
    bus.req_sel[i*S +: S] = S'(sel);
    bus.req_wdata[i*F +: F] = wd;
  endtask

  task automatic wait_ack(input int i, output int n);
    bit seen = 1'b0;
    n = 0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      seen = bus.ack[i];
    end
    chk($sformatf("ack%0d_seen", i), 32'(seen), 32'd1);
  endtask

  initial begin
    int n;
    int order[$];
    int when[$];
    int cyc;
    int exp_order[5];
    bus.req       = '0;
    bus.req_wr    = '0;
    bus.req_sel   = '0;
    bus.req_wdata = '0;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_strobes", 32'({bus.sw_wr, bus.sw_rd}), 32'd0);
    chk("rst_rdata_err", 32'({bus.rdata, bus.err}), 32'd0);
    #1 rst = 1'b0;

    // Single write to alias 1 from requester 1.
    @(negedge clk); #1 drive(1, 1'b1, 1, 4'hA);
    @(negedge clk);
    chk("t1_sw_wr", 32'(bus.sw_wr), 32'h2);
    chk("t1_sw_wr_data", 32'(bus.sw_wr_data), 32'hA0);
    @(negedge clk);
    chk("t1_ack", 32'(bus.ack), 32'h2);
    chk("t1_err", 32'(bus.err), 32'd0);
    #1 bus.req[1] = 1'b0;
    @(negedge clk);
    chk("t1_idle", 32'(bus.busy), 32'd0);
    chk("t1_field", 32'(fld), 32'hA);

    // Load 5 through alias 0, then read it back through the read-clear alias.
    #1 drive(0, 1'b1, 0, 4'h5);
    wait_ack(0, n);
    #1 bus.req[0] = 1'b0;
    @(negedge clk); #1 drive(0, 1'b0, 0, 4'h0);
    @(negedge clk);
    chk("t2_sw_rd", 32'(bus.sw_rd), 32'h1);
    chk("t2_sw_wr", 32'(bus.sw_wr), 32'h0);
    @(negedge clk);
    chk("t2_ack", 32'(bus.ack), 32'h1);
    chk("t2_rdata", 32'(bus.rdata), 32'h5);
    chk("t2_field_cleared", 32'(fld), 32'h0);
    #1 bus.req[0] = 1'b0;

    // All four held from ptr 0: grants 0,1,2,3,0 three cycles apart.
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    grant_log.delete();
    drive(0, 1'b0, 1, 4'h0);
    drive(1, 1'b1, 1, 4'h3);
    drive(2, 1'b0, 0, 4'h0);
    drive(3, 1'b1, 0, 4'hC);
    cyc = 0;
    while (order.size() < 5 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != '0) begin
        order.push_back($clog2(bus.ack));
        when.push_back(cyc);
      end
    end
    #1 bus.req = '0;
    exp_order = '{0, 1, 2, 3, 0};
    chk("t3_ack_count", 32'(order.size()), 32'd5);
    chk("t3_model_grants", 32'(grant_log.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < order.size()) chk($sformatf("t3_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
      if (k < grant_log.size())
        chk($sformatf("t3_model%0d", k), 32'(grant_log[k]), 32'(exp_order[k]));
      if (k > 0 && k < when.size())
        chk($sformatf("t3_gap%0d", k), 32'(when[k] - when[k-1]), 32'd3);
    end

    // Out-of-range alias: no strobe, error flagged, rdata zero.
    @(negedge clk); #1 drive(2, 1'b0, 3, 4'h0);
    @(negedge clk);
    chk("t4_no_strobe", 32'({bus.sw_wr, bus.sw_rd}), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("t4_ack", 32'(bus.ack), 32'h4);
    chk("t4_err", 32'(bus.err), 32'd1);
    chk("t4_rdata", 32'(bus.rdata), 32'd0);
    #1 bus.req[2] = 1'b0;

    // Reset during ACCESS kills the strobe at once; a fresh request sees normal latency.
    @(negedge clk); #1 drive(1, 1'b1, 0, 4'h7);
    @(posedge clk); #2;
    chk("t5_strobe_before", 32'(bus.sw_wr), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_strobe_async_drop", 32'(bus.sw_wr), 32'h0);
    chk("t5_busy_drop", 32'(bus.busy), 32'd0);
    bus.req[1] = 1'b0;
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_no_ack", 32'(bus.ack), 32'd0);
    #1 drive(2, 1'b1, 1, 4'h3);
    wait_ack(2, n);
    chk("t5_latency", 32'(n), 32'd2);
    #1 bus.req[2] = 1'b0;

    // Requester 3 drops req right after its grant; requester 0 is served next.
    @(negedge clk); #1;
    drive(3, 1'b1, 1, 4'h9);
    drive(0, 1'b0, 1, 4'h0);
    @(negedge clk);
    chk("t6_sw_wr", 32'(bus.sw_wr), 32'h2);
    #1 bus.req[3] = 1'b0;
    @(negedge clk);
    chk("t6_ack3", 32'(bus.ack), 32'h8);
    wait_ack(0, n);
    chk("t6_next_latency", 32'(n), 32'd3);
    chk("t6_rdata", 32'(bus.rdata), 32'h9);
    #1 bus.req[0] = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1, "timeout");
  end

endmodule
